bldc_gate_driver: RTL and testbench

Downstream stage of the commutation controller. Takes the six-bit commutation pattern, chops the high-side switches with a PWM carrier, and inserts a programmable dead time before any switch turns on after its same-phase complement. It also detects shoot-through requests and latches a fault. Its outputs drive the external half-bridge gate drivers directly.

---
 rtl/bldc_gate_pkg.sv | 21 ++
 rtl/phase_deadtime.sv | 74 +++++++
 rtl/bldc_gate_driver.sv | 85 ++++++++
 tb/tb_bldc_gate_driver.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bldc_gate_pkg.sv
// Shared phase-state type, field offsets and sizing helper for the BLDC gate driver.
package bldc_gate_pkg;

  typedef enum logic [1:0] {IDLE, HI, LO, DEAD} phase_state_e;

  localparam int PH_A = 2;
  localparam int PH_B = 1;
  localparam int PH_C = 0;

  localparam int HI_BASE = 3;
  localparam int LO_BASE = 0;

  // Width of the dead-time counter; never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/phase_deadtime.sv
// One half-bridge phase: IDLE/HI/LO/DEAD state machine with dead-time insertion.
module phase_deadtime
  import bldc_gate_pkg::*;
#(
  parameter int DEADTIME = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_hi_i,
  input  logic req_lo_i,
  input  logic force_dead_i,
  output logic gate_hi_o,
  output logic gate_lo_o
);

  localparam int DT_W = clog2(DEADTIME);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

  phase_state_e    state_q, state_d, reqState;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            gate_hi_q, gate_lo_q;

  always_comb begin
    reqState = IDLE;
    if (req_hi_i && !req_lo_i) reqState = HI;
    else if (req_lo_i && !req_hi_i) reqState = LO;
  end

  // Any switch-off passes through DEAD, so a gate can never turn on right after its complement.
  always_comb begin
    state_d = state_q;
    dt_d    = dt_q;
    if (force_dead_i) begin
      state_d = DEAD;
      dt_d    = DT_LOAD;
    end else begin
      case (state_q)
        IDLE: state_d = reqState;
        HI, LO: begin
          if (reqState != state_q) begin
            state_d = DEAD;
            dt_d    = DT_LOAD;
          end
        end
        DEAD: begin
          if (dt_q == '0) state_d = reqState;
          else dt_d = dt_q - DT_W'(1);
        end
        default: begin
          state_d = DEAD;
          dt_d    = DT_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DEAD;
      dt_q      <= DT_LOAD;
      gate_hi_q <= 1'b0;
      gate_lo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dt_q      <= dt_d;
      gate_hi_q <= (state_d == HI);
      gate_lo_q <= (state_d == LO);
    end
  end

  assign gate_hi_o = gate_hi_q;
  assign gate_lo_o = gate_lo_q;

endmodule

// File: rtl/bldc_gate_driver.sv
// Gate driver: registers the commutation pattern, PWM-chops the high side,
// and feeds three dead-time phases with a sticky shoot-through fault.
module bldc_gate_driver
  import bldc_gate_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          pt_in,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                pwm_en,
  input  logic                fault_clr,
  output logic [2:0]          gate_hi,
  output logic [2:0]          gate_lo,
  output logic                fault
);

  logic [5:0]          pt_q;
  logic [PWM_BITS-1:0] cnt_q, duty_q;
  logic                fault_q, fault_d;
  logic                pwmOn, illegalReq, forceDead;
  logic [2:0]          hiReq, loReq;

  assign pwmOn      = cnt_q < duty_q;
  assign hiReq      = pt_q[HI_BASE +: 3] & {3{pwmOn | ~pwm_en}};
  assign loReq      = pt_q[LO_BASE +: 3];
  assign illegalReq = |(pt_q[HI_BASE +: 3] & loReq);
  // The raw illegal request forces DEAD in the same edge that sets the fault.
  assign forceDead  = fault_q | illegalReq;

  always_comb begin
    fault_d = fault_q;
    if (illegalReq) fault_d = 1'b1;
    else if (fault_clr) fault_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q    <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      pt_q    <= pt_in;
      cnt_q   <= cnt_q + PWM_BITS'(1);
      fault_q <= fault_d;
      if (cnt_q == '1) duty_q <= duty;
    end
  end

  assign fault = fault_q;

  phase_deadtime #(.DEADTIME(DEADTIME)) u_phase_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_hi_i     (hiReq[PH_A]),
    .req_lo_i     (loReq[PH_A]),
    .force_dead_i (forceDead),
    .gate_hi_o    (gate_hi[PH_A]),
    .gate_lo_o    (gate_lo[PH_A])
  );

  phase_deadtime #(.DEADTIME(DEADTIME)) u_phase_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_hi_i     (hiReq[PH_B]),
    .req_lo_i     (loReq[PH_B]),
    .force_dead_i (forceDead),
    .gate_hi_o    (gate_hi[PH_B]),
    .gate_lo_o    (gate_lo[PH_B])
  );

  phase_deadtime #(.DEADTIME(DEADTIME)) u_phase_c (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_hi_i     (hiReq[PH_C]),
    .req_lo_i     (loReq[PH_C]),
    .force_dead_i (forceDead),
    .gate_hi_o    (gate_hi[PH_C]),
    .gate_lo_o    (gate_lo[PH_C])
  );

endmodule

// File: tb/tb_bldc_gate_driver.sv
// Directed bench for bldc_gate_driver: per-cycle vector table plus PWM period counts.
module tb_bldc_gate_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] pt_in = '0;
  logic [7:0] duty = '0;
  logic       pwm_en = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] gate_hi, gate_lo;
  logic       fault;

  int vecCount = 0;
  int errCount = 0;

  typedef struct {
    logic [5:0] pt;
    logic       clr;
    logic [2:0] expHi;
    logic [2:0] expLo;
    logic       expFault;
  } vec_t;

  vec_t vecs[$];

  bldc_gate_driver #(.DEADTIME(8), .PWM_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pt_in     (pt_in),
    .duty      (duty),
    .pwm_en    (pwm_en),
    .fault_clr (fault_clr),
    .gate_hi   (gate_hi),
    .gate_lo   (gate_lo),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic [5:0] pt, input logic clr, input logic [2:0] hi,
                        input logic [2:0] lo, input logic f, input int repeatCount);
    vec_t v;
    v.pt = pt; v.clr = clr; v.expHi = hi; v.expLo = lo; v.expFault = f;
    for (int i = 0; i < repeatCount; i++) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [5:0] pt, input logic en, input logic [7:0] d,
                               input logic clr);
    pt_in = pt; pwm_en = en; duty = d; fault_clr = clr;
  endtask

  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expHi, input logic [2:0] expLo,
                             input logic expFault);
    vecCount++;
    if (gate_hi !== expHi || gate_lo !== expLo || fault !== expFault) begin
      errCount++;
      $display("[TB] FAIL %s: gate_hi=%b gate_lo=%b fault=%b, expected gate_hi=%b gate_lo=%b fault=%b",
               name, gate_hi, gate_lo, fault, expHi, expLo, expFault);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      errCount++;
      $display("[TB] FAIL %s: counted %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic runTable(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].pt, 1'b0, 8'd0, vecs[i].clr);
      stepClock();
      checkOutput($sformatf("%s vec%0d", tag, i + 1), vecs[i].expHi, vecs[i].expLo, vecs[i].expFault);
    end
    fault_clr = 1'b0;
  endtask

  task automatic runPeriod(input int changeAt, input logic [7:0] newDuty,
                           output int hiCnt, output int loCnt, output int overlap);
    hiCnt = 0; loCnt = 0; overlap = 0;
    for (int s = 1; s <= 256; s++) begin
      stepClock();
      if (gate_hi == 3'b100) hiCnt++;
      if (gate_lo == 3'b010) loCnt++;
      if ((gate_hi & gate_lo) != 3'b000) overlap++;
      if (s == changeAt) duty = newDuty;
    end
  endtask

  initial begin
    int hiCnt, loCnt, overlap;
    int expHiCnt[6] = '{0, 64, 128, 0, 255, 248};
    logic [7:0] nextDuty[6] = '{8'd64, 8'd128, 8'd0, 8'd255, 8'd255, 8'd255};

    // Edge numbering counts posedges after rst_n release; vector n is checked after edge n.
    addVec(6'b100001, 1'b0, 3'b000, 3'b000, 1'b0, 7);
    addVec(6'b100001, 1'b0, 3'b100, 3'b001, 1'b0, 3);
    addVec(6'b001100, 1'b0, 3'b100, 3'b001, 1'b0, 1);
    addVec(6'b001100, 1'b0, 3'b000, 3'b000, 1'b0, 8);
    addVec(6'b001100, 1'b0, 3'b001, 3'b100, 1'b0, 2);
    addVec(6'b100100, 1'b0, 3'b001, 3'b100, 1'b0, 1);
    addVec(6'b100100, 1'b1, 3'b000, 3'b000, 1'b1, 2);
    addVec(6'b100001, 1'b0, 3'b000, 3'b000, 1'b1, 1);
    addVec(6'b100001, 1'b1, 3'b000, 3'b000, 1'b0, 1);
    addVec(6'b100001, 1'b0, 3'b000, 3'b000, 1'b0, 7);
    addVec(6'b100001, 1'b0, 3'b100, 3'b001, 1'b0, 2);

    applyStimulus(6'b100001, 1'b0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("in reset", 3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    runTable(0, vecs.size() - 1, "table");

    // PWM periods start from a fresh reset so cnt is aligned with the edge count.
    #2 rst_n = 1'b0;
    applyStimulus(6'b100010, 1'b1, 8'd64, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 6; p++) begin
      runPeriod(44, nextDuty[p], hiCnt, loCnt, overlap);
      checkCount($sformatf("period%0d hi", p + 1), hiCnt, expHiCnt[p]);
      checkCount($sformatf("period%0d lo", p + 1), loCnt, (p == 0) ? 249 : 256);
      checkCount($sformatf("period%0d overlap", p + 1), overlap, 0);
    end

    pwm_en = 1'b0;
    repeat (12) stepClock();
    checkOutput("before async reset", 3'b100, 3'b010, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async reset", 3'b000, 3'b000, 1'b0);
    applyStimulus(6'b100001, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    checkOutput("async reset held", 3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    runTable(0, 9, "rerelease");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
